// File: rtl/cond_eval_unit.sv
// Condition-code evaluation unit: NCH channels decode 4-bit condition codes
// against {N,Z,C,V} flags, returning results through a one-deep valid/ready stage.
module cond_eval_unit #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned FWD     = 1,
  parameter int unsigned NV_TRUE = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [3:0]       flag_in,
  input  logic             q_set,
  input  logic             q_clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4*NCH-1:0] req_cc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NCH-1:0]   rsp_cond,
  output logic [3:0]       flags_out,
  output logic             q_flag,
  output logic [CNT_W-1:0] eval_cnt
);

  localparam logic NV_RES  = (NV_TRUE != 0);
  localparam logic USE_FWD = (FWD != 0);

  logic [3:0]       flags_q, flags_d;
  logic             q_q, q_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [NCH-1:0]   rsp_cond_q, rsp_cond_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       eff_flags;
  logic [NCH-1:0]   cond_c;
  logic             accept;

  // Flags are ordered {N,Z,C,V}.
  function automatic logic decode(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c & !z;
      4'h9:    res = !c | z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z & (n == v);
      4'hD:    res = z | (n != v);
      4'hE:    res = 1'b1;
      default: res = NV_RES;
    endcase
    return res;
  endfunction

  assign req_ready = !rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready & !reset;

  always_comb begin
    eff_flags = flags_q;
    cond_c    = '0;
    if (USE_FWD && flag_we) eff_flags = flag_in;
    for (int i = 0; i < NCH; i++) cond_c[i] = decode(req_cc[4*i +: 4], eff_flags);
  end

  always_comb begin
    flags_d     = flags_q;
    q_d         = q_q;
    rsp_valid_d = rsp_valid_q;
    rsp_cond_d  = rsp_cond_q;
    cnt_d       = cnt_q;
    if (flag_we) flags_d = flag_in;
    if (q_clr) q_d = 1'b0;
    if (q_set) q_d = 1'b1;
    // A fresh accept reloads the stage even while the old result drains.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_cond_d  = cond_c;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= '0;
      q_q         <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_cond_q  <= '0;
      cnt_q       <= '0;
    end else begin
      flags_q     <= flags_d;
      q_q         <= q_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cond_q  <= rsp_cond_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_cond  = rsp_cond_q;
  assign flags_out = flags_q;
  assign q_flag    = q_q;
  assign eval_cnt  = cnt_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Bench for cond_eval_unit: instance a uses defaults (FWD=1, NV_TRUE=0),
// instance b uses FWD=0, NV_TRUE=1, CNT_W=4; both share the same stimulus.
module tb_cond_eval_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, flag_we, q_set, q_clr, req_valid, rsp_ready;
  logic [3:0] flag_in;
  logic [7:0] req_cc;

  logic        req_ready_a, rsp_valid_a, q_flag_a;
  logic [1:0]  rsp_cond_a;
  logic [3:0]  flags_out_a;
  logic [15:0] eval_cnt_a;
  logic        req_ready_b, rsp_valid_b, q_flag_b;
  logic [1:0]  rsp_cond_b;
  logic [3:0]  flags_out_b;
  logic [3:0]  eval_cnt_b;

  cond_eval_unit u_a (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_in(flag_in),
    .q_set(q_set), .q_clr(q_clr), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_cc(req_cc), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_cond(rsp_cond_a), .flags_out(flags_out_a), .q_flag(q_flag_a),
    .eval_cnt(eval_cnt_a)
  );

  cond_eval_unit #(.NCH(2), .FWD(0), .NV_TRUE(1), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_in(flag_in),
    .q_set(q_set), .q_clr(q_clr), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_cc(req_cc), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_cond(rsp_cond_b), .flags_out(flags_out_b), .q_flag(q_flag_b),
    .eval_cnt(eval_cnt_b)
  );

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  logic        m_valid = 1'b0;
  logic        m_q     = 1'b0;
  logic [3:0]  m_flags = 4'h0;
  int unsigned m_cnt   = 0;

  function automatic logic ref_dec(input logic [3:0] cc, input logic [3:0] f, input logic nv);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return c;
      4'd3:  return ~c;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return c && !z;
      4'd9:  return !(c && !z);
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return !z && (n ~^ v);
      4'd13: return !(!z && (n ~^ v));
      4'd14: return 1'b1;
      default: return nv;
    endcase
  endfunction

  task automatic idle();
    reset = 1'b0; flag_we = 1'b0; flag_in = 4'h0; q_set = 1'b0; q_clr = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b1; req_cc = 8'h00;
  endtask

  // One clock: check outputs against the model, update scoreboard and model.
  task automatic step();
    exp_t       e;
    logic       acc;
    logic [3:0] eff_a;
    #1;
    checks++;
    if (req_ready_a !== (!m_valid || rsp_ready) || req_ready_b !== (!m_valid || rsp_ready)) begin
      errors++;
      $display("FAIL req_ready: got a=%b b=%b want %b", req_ready_a, req_ready_b, !m_valid || rsp_ready);
    end
    checks++;
    if (rsp_valid_a !== m_valid || rsp_valid_b !== m_valid) begin
      errors++;
      $display("FAIL rsp_valid: got a=%b b=%b want %b", rsp_valid_a, rsp_valid_b, m_valid);
    end
    checks++;
    if (flags_out_a !== m_flags || flags_out_b !== m_flags || q_flag_a !== m_q || q_flag_b !== m_q ||
        eval_cnt_a !== 16'(m_cnt) || eval_cnt_b !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL state: got flags=%h/%h q=%b/%b cnt=%0d/%0d want flags=%h q=%b cnt=%0d/%0d",
               flags_out_a, flags_out_b, q_flag_a, q_flag_b, eval_cnt_a, eval_cnt_b,
               m_flags, m_q, 16'(m_cnt), 4'(m_cnt));
    end
    if (m_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got valid response want empty queue");
      end else if (rsp_cond_a !== sb[0].a || rsp_cond_b !== sb[0].b) begin
        errors++;
        $display("FAIL rsp_cond: got a=%b b=%b want a=%b b=%b", rsp_cond_a, rsp_cond_b, sb[0].a, sb[0].b);
      end
      if (rsp_ready && !reset && sb.size() != 0) begin
        void'(sb.pop_front());
        pops++;
      end
    end
    acc   = req_valid && (!m_valid || rsp_ready) && !reset;
    eff_a = flag_we ? flag_in : m_flags;
    if (acc) begin
      e.a = {ref_dec(req_cc[7:4], eff_a, 1'b0), ref_dec(req_cc[3:0], eff_a, 1'b0)};
      e.b = {ref_dec(req_cc[7:4], m_flags, 1'b1), ref_dec(req_cc[3:0], m_flags, 1'b1)};
      sb.push_back(e);
    end
    if (reset) begin
      m_valid = 1'b0; m_q = 1'b0; m_flags = 4'h0; m_cnt = 0;
      sb.delete();
    end else begin
      if (flag_we) m_flags = flag_in;
      if (q_clr) m_q = 1'b0;
      if (q_set) m_q = 1'b1;
      m_valid = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_valid);
      if (acc) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid_a !== 1'b0 || rsp_cond_a !== 2'b00 || flags_out_a !== 4'h0 || q_flag_a !== 1'b0 ||
        eval_cnt_a !== 16'h0 || eval_cnt_b !== 4'h0 || req_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset: got valid=%b cond=%b flags=%h q=%b cnt=%0d rdy=%b want all 0 and rdy=1",
               rsp_valid_a, rsp_cond_a, flags_out_a, q_flag_a, eval_cnt_a, req_ready_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    for (int f = 0; f < 16; f++) begin
      idle();
      flag_we = 1'b1;
      flag_in = 4'(f);
      step();
      idle();
      req_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        req_cc = {4'(15 - c), 4'(c)};
        step();
      end
    end
    idle();
    step();
  endtask

  task automatic test_bypass();
    idle();
    flag_we = 1'b1;
    flag_in = 4'h0;
    step();
    flag_in = 4'h4;
    req_valid = 1'b1;
    req_cc = 8'h00;
    step();
    idle();
    checks++;
    if (rsp_cond_a[0] !== 1'b1 || rsp_cond_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass: got fwd=%b nofwd=%b want fwd=1 nofwd=0", rsp_cond_a[0], rsp_cond_b[0]);
    end
    step();
  endtask

  task automatic test_backpressure();
    idle();
    flag_we = 1'b1;
    flag_in = 4'h4;
    step();
    idle();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_cc = 8'h10;
    step();
    req_cc = 8'h01;
    flag_we = 1'b1;
    flag_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready_a !== 1'b0 || rsp_cond_a !== 2'b01 || rsp_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold: got rdy=%b cond=%b valid=%b want rdy=0 cond=01 valid=1",
                 req_ready_a, rsp_cond_a, rsp_valid_a);
      end
      step();
      flag_we = 1'b0;
    end
    flag_we = 1'b1;
    flag_in = 4'h4;
    rsp_ready = 1'b1;
    step();
    idle();
    checks++;
    if (rsp_cond_a !== 2'b10 || rsp_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_b: got cond=%b valid=%b want cond=10 valid=1", rsp_cond_a, rsp_valid_a);
    end
    step();
  endtask

  task automatic test_streaming();
    do_reset();
    pops = 0;
    idle();
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_cc = 8'($urandom_range(0, 255));
      flag_we = 1'($urandom_range(0, 1));
      flag_in = 4'($urandom_range(0, 15));
      step();
    end
    idle();
    step();
    checks++;
    if (pops != 10 || eval_cnt_a !== 16'd10) begin
      errors++;
      $display("FAIL streaming: got results=%0d cnt=%0d want 10 and 10", pops, eval_cnt_a);
    end
  endtask

  task automatic test_wrap_sticky();
    do_reset();
    idle();
    req_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_cc = 8'(i * 17);
      step();
    end
    idle();
    q_set = 1'b1;
    q_clr = 1'b1;
    step();
    idle();
    checks++;
    if (eval_cnt_b !== 4'd1 || eval_cnt_a !== 16'd17 || q_flag_a !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky: got cnt4=%0d cnt16=%0d q=%b want 1 17 1", eval_cnt_b, eval_cnt_a, q_flag_a);
    end
    q_clr = 1'b1;
    step();
    idle();
    checks++;
    if (q_flag_a !== 1'b0) begin
      errors++;
      $display("FAIL q_clear: got q=%b want 0", q_flag_a);
    end
  endtask

  task automatic test_reset_stall();
    idle();
    flag_we = 1'b1;
    flag_in = 4'hF;
    q_set = 1'b1;
    step();
    idle();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_cc = 8'hEE;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid_a !== 1'b0 || rsp_cond_a !== 2'b00 || flags_out_a !== 4'h0 || q_flag_a !== 1'b0 ||
        eval_cnt_a !== 16'h0 || req_ready_a !== 1'b1 || rsp_valid_b !== 1'b0 || rsp_cond_b !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall: got valid=%b cond=%b flags=%h q=%b cnt=%0d rdy=%b want zeros and rdy=1",
               rsp_valid_a, rsp_cond_a, flags_out_a, q_flag_a, eval_cnt_a, req_ready_a);
    end
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_decode();
    test_bypass();
    test_backpressure();
    test_streaming();
    test_wrap_sticky();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
